// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: digit encoding
// and the operand-extension / digit-count arithmetic used by every stage.
package booth_pkg;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_P1,
    BD_P2,
    BD_M1,
    BD_M2
  } booth_digit_t;

  // Overlapping triplet {b[2i+1], b[2i], b[2i-1]} to a signed digit in -2..+2.
  function automatic booth_digit_t booth_enc(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return BD_P1;
      3'b011:         return BD_P2;
      3'b100:         return BD_M2;
      3'b101, 3'b110: return BD_M1;
      default:        return BD_ZERO;
    endcase
  endfunction

  function automatic int ew(input int w);
    return w + 2;
  endfunction

  function automatic int npp(input int w);
    return (w + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_fa.sv
// Full-adder cell used to build the carry-save reduction tree.
module booth_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/booth_pp_gen.sv
// One Booth partial product: selects 0, A or 2A for the digit and inverts it
// for negative digits; the +1 of the two's complement is returned as o_neg.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int EW = 10
) (
  input  logic [EW-1:0] i_a_ext,
  input  booth_digit_t  i_digit,
  output logic [EW:0]   o_pp,
  output logic          o_neg
);

  logic [EW:0] w_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    w_sel = '0;
    o_neg = 1'b0;
    case (i_digit)
      BD_P1: w_sel = {i_a_ext[EW-1], i_a_ext};
      BD_P2: w_sel = {i_a_ext, 1'b0};
      BD_M1: begin
        w_sel = {i_a_ext[EW-1], i_a_ext};
        o_neg = 1'b1;
      end
      BD_M2: begin
        w_sel = {i_a_ext, 1'b0};
        o_neg = 1'b1;
      end
      default: ;
    endcase
    o_pp = o_neg ? ~w_sel : w_sel;
  end

endmodule

// File: rtl/booth_mult_pipe.sv
// Radix-4 Booth multiplier, 3 registered stages (encode, carry-save reduce,
// final add) with valid/ready on both sides and collapsing bubbles.
module booth_mult_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int EW   = ew(WIDTH);
  localparam int NPP  = npp(WIDTH);
  localparam int PP_W = EW + 1;
  localparam int PW   = 2 * WIDTH;
  localparam int NROW = NPP + 2;
  localparam int NLVL = NROW - 2;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_pipe: WIDTH must be even and >= 4");
  end

  // Each row's sign bit is stored complemented; this constant removes the
  // 2^(PP_W-1) bias that the complement adds to every row.
  function automatic logic [PW-1:0] sign_const();
    logic [PW-1:0] k;
    k = '0;
    for (int i = 0; i < NPP; i++) begin
      k = k - (PW'(1) << (PP_W - 1 + 2 * i));
    end
    return k;
  endfunction

  localparam logic [PW-1:0] SIGN_K = sign_const();

  // ---------------- flow control ----------------
  logic r_s1_v, r_s2_v, r_s3_v;
  logic w_adv1, w_adv2, w_adv3;

  assign w_adv3   = !r_s3_v || out_ready;
  assign w_adv2   = !r_s2_v || w_adv3;
  assign w_adv1   = !r_s1_v || w_adv2;
  assign in_ready = w_adv1;

  // ---------------- S1: extend and encode ----------------
  logic [EW-1:0]   w_a_ext;
  logic [EW-1:0]   w_b_ext;
  logic [EW:0]     w_b_pad;
  booth_digit_t    w_digit [NPP];
  logic [PP_W-1:0] w_pp    [NPP];
  logic [NPP-1:0]  w_neg;

  assign w_a_ext = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
  assign w_b_ext = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
  assign w_b_pad = {w_b_ext, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    assign w_digit[i] = booth_enc(w_b_pad[2*i +: 3]);
    booth_pp_gen #(.EW(EW)) u_pp_gen (
      .i_a_ext (w_a_ext),
      .i_digit (w_digit[i]),
      .o_pp    (w_pp[i]),
      .o_neg   (w_neg[i])
    );
  end

  logic [PP_W-1:0]  r_pp [NPP];
  logic [NPP-1:0]   r_neg;
  logic [TAG_W-1:0] r_s1_tag;

  // ---------------- S2: carry-save reduction ----------------
  logic [PW-1:0] w_rows  [NROW];
  logic [PW-1:0] w_csa_x [NLVL];
  logic [PW-1:0] w_csa_y [NLVL];
  logic [PW-1:0] w_csa_z [NLVL];
  logic [PW-1:0] w_csa_s [NLVL];
  logic [PW-1:0] w_csa_c [NLVL];

  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      w_rows[i] = PW'({~r_pp[i][PP_W-1], r_pp[i][PP_W-2:0]}) << (2 * i);
    end
    w_rows[NPP] = '0;
    for (int i = 0; i < NPP; i++) begin
      w_rows[NPP][2*i] = r_neg[i];
    end
    w_rows[NPP+1] = SIGN_K;
  end

  // Chain of 3:2 compressors; carries leave each level already shifted by one
  // and the carry out of the top bit is dropped (result is mod 2^PW).
  for (genvar k = 0; k < NLVL; k++) begin : g_lvl
    if (k == 0) begin : g_first
      assign w_csa_x[k] = w_rows[0];
      assign w_csa_y[k] = w_rows[1];
      assign w_csa_z[k] = w_rows[2];
    end else begin : g_next
      assign w_csa_x[k] = w_csa_s[k-1];
      assign w_csa_y[k] = w_csa_c[k-1];
      assign w_csa_z[k] = w_rows[k+2];
    end

    assign w_csa_c[k][0]    = 1'b0;
    assign w_csa_s[k][PW-1] = w_csa_x[k][PW-1] ^ w_csa_y[k][PW-1] ^ w_csa_z[k][PW-1];

    for (genvar b = 0; b < PW - 1; b++) begin : g_bit
      booth_fa u_fa (
        .i_a  (w_csa_x[k][b]),
        .i_b  (w_csa_y[k][b]),
        .i_c  (w_csa_z[k][b]),
        .o_s  (w_csa_s[k][b]),
        .o_co (w_csa_c[k][b+1])
      );
    end
  end

  logic [PW-1:0]    r_s2_sum;
  logic [PW-1:0]    r_s2_carry;
  logic [TAG_W-1:0] r_s2_tag;

  // ---------------- S3: final add ----------------
  logic [PW-1:0]    r_out_p;
  logic [TAG_W-1:0] r_out_tag;

  // NOTE: only control and the visible outputs are reset; the datapath
  // registers are qualified by their valid bit, so their contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      // NOTE: non-blocking assignments here so every stage samples the previous stage's old value.
      r_pp     <= w_pp;
      r_neg    <= w_neg;
      r_s1_tag <= in_tag;
    end
    if (w_adv2 && r_s1_v) begin
      r_s2_sum   <= w_csa_s[NLVL-1];
      r_s2_carry <= w_csa_c[NLVL-1];
      r_s2_tag   <= r_s1_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_out_p   <= '0;
      r_out_tag <= '0;
    end else begin
      if (w_adv1) r_s1_v <= in_valid;
      if (w_adv2) r_s2_v <= r_s1_v;
      if (w_adv3) r_s3_v <= r_s2_v;
      if (w_adv3 && r_s2_v) begin
        r_out_p   <= r_s2_sum + r_s2_carry;
        r_out_tag <= r_s2_tag;
      end
    end
  end

  assign out_valid = r_s3_v;
  assign out_p     = r_out_p;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Directed and scoreboarded checks of booth_mult_pipe at WIDTH=8: hand-computed
// products, latency/throughput, backpressure, mid-flight reset, random stalls.
module tb_booth_mult_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  booth_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [3:0]  tag;
    logic [15:0] exp;
  } op_t;

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  tag;
    int          cyc;
  } sb_t;

  op_t src[$];
  sb_t sb[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_drn = 0;
  bit          chk_lat = 1'b0;
  logic        hold_vld = 1'b0;
  logic [15:0] hold_p;
  logic [3:0]  hold_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] r;
    if (s) r = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    else   r = {8'h00, a} * {8'h00, b};
    return r;
  endfunction

  task automatic add_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [3:0] tag, input logic [15:0] exp);
    src.push_back('{a: a, b: b, s: s, tag: tag, exp: exp});
  endtask

  task automatic add_rand(input logic [3:0] tag);
    logic [7:0] a, b;
    logic       s;
    a = 8'($urandom);
    b = 8'($urandom);
    s = 1'($urandom);
    add_op(a, b, s, tag, model(a, b, s));
  endtask

  // One clock: present the head of src, sample away from the edge, score
  // any output transfer, record any input transfer, then cross the edge.
  task automatic cycle();
    sb_t e;
    if (src.size() > 0) begin
      in_valid  = 1'b1;
      in_a      = src[0].a;
      in_b      = src[0].b;
      in_signed = src[0].s;
      in_tag    = src[0].tag;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (hold_vld) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_p", 32'(out_p), 32'(hold_p));
      check("hold_tag", 32'(out_tag), 32'(hold_tag));
    end
    hold_vld = out_valid && !out_ready;
    hold_p   = out_p;
    hold_tag = out_tag;
    if (out_valid && out_ready) begin
      n_drn++;
      check("expected_output_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("product", 32'(out_p), 32'(e.p));
        check("tag", 32'(out_tag), 32'(e.tag));
        if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back('{p: src[0].exp, tag: src[0].tag, cyc: cyc});
      void'(src.pop_front());
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src.size() > 0 || sb.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_complete", 32'(src.size() + sb.size()), 32'd0);
  endtask

  initial begin
    int a0, d0, c0;

    // Reset values.
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed hand-computed products, back to back, unstalled.
    chk_lat = 1'b1;
    d0 = n_drn;
    add_op(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
    add_op(8'hFF, 8'h01, 1'b1, 4'h2, 16'hFFFF);
    add_op(8'h7F, 8'h80, 1'b1, 4'h3, 16'hC080);
    add_op(8'hFF, 8'hFF, 1'b0, 4'h4, 16'hFE01);
    add_op(8'h00, 8'hC8, 1'b0, 4'h5, 16'h0000);
    add_op(8'hFF, 8'hFF, 1'b1, 4'h6, 16'h0001);
    add_op(8'h80, 8'h7F, 1'b0, 4'h7, 16'h3F80);
    add_op(8'h05, 8'hFD, 1'b1, 4'h8, 16'hFFF1);
    drain(40);
    check("directed_count", 32'(n_drn - d0), 32'd8);

    // Throughput: 20 back-to-back random ops accepted in 20 cycles.
    a0 = n_acc; d0 = n_drn; c0 = cyc;
    for (int i = 0; i < 20; i++) add_rand(4'(i));
    while (src.size() > 0 && cyc - c0 < 40) cycle();
    check("tp_accept_cycles", 32'(cyc - c0), 32'd20);
    check("tp_accepts", 32'(n_acc - a0), 32'd20);
    drain(20);
    check("tp_results", 32'(n_drn - d0), 32'd20);

    // Backpressure: 10 stalled cycles with continuous input.
    chk_lat = 1'b0;
    a0 = n_acc; d0 = n_drn;
    for (int i = 0; i < 10; i++) add_rand(4'(i + 3));
    out_ready = 1'b0;
    repeat (10) cycle();
    check("bp_accepts", 32'(n_acc - a0), 32'd3);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain(60);
    check("bp_results", 32'(n_drn - d0), 32'd10);

    // Reset with three ops in flight.
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 3; i++) add_rand(4'(i + 9));
    for (int n = 0; n < 10 && n_acc - a0 < 3; n++) cycle();
    check("rst_mid_accepts", 32'(n_acc - a0), 32'd3);
    check("rst_mid_full", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    hold_vld = 1'b0;
    sb.delete();
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_p", 32'(out_p), 32'd0);
    out_ready = 1'b1;
    d0 = n_drn;
    repeat (5) cycle();
    check("rst_flushed_not_emitted", 32'(n_drn - d0), 32'd0);
    chk_lat = 1'b1;
    add_op(8'h12, 8'h34, 1'b0, 4'hA, 16'h03A8);
    drain(10);
    check("rst_new_op", 32'(n_drn - d0), 32'd1);

    // Random operands, both modes, random output stalls.
    chk_lat = 1'b0;
    d0 = n_drn;
    for (int i = 0; i < 150; i++) add_rand(4'(i));
    for (int n = 0; n < 2000 && (src.size() > 0 || sb.size() > 0); n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    drain(10);
    check("rand_results", 32'(n_drn - d0), 32'd150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
